regfile_rob: RTL and testbench
==============================

Name: regfile_rob

Overview:
- Architectural register file with per-register rename tags. It receives the allocate and commit stream that the ROB drives.
- On dispatch, the ROB marks a destination register busy under a ROB tag.
- On commit, the ROB writes the result, taken from the CDB or from d-cache load data. The busy bit clears only if the committing tag is still the youngest owner.
- Supplies operands (value or pending tag) to the instruction queue and store data to the ROB/d-cache path.

Parameters:
- NUM_REGS, 32, architectural registers; x0 is hardwired zero.
- DATA_W, 32, register width.
- TAG_W, 3, ROB tag width (8-entry ROB).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- regfile_allocate  in  1  mark rd_inflight busy with rob_tag.
- rd_inflight  in  5  destination register being allocated.
- rob_tag  in  TAG_W  ROB entry that owns rd_inflight.
- regfile_load  in  1  commit a result.
- commit_rd  in  5  register being committed.
- commit_tag  in  TAG_W  ROB entry committing.
- ld_commit_sel  in  1  commit data source: 1 = dmem_rdata, 0 = cdb_data.
- cdb_data  in  DATA_W  ALU/branch result.
- dmem_rdata  in  DATA_W  d-cache load data.
- flush  in  1  branch mispredict; clear every busy bit.
- rs1, rs2  in  5 each  IQ operand selects.
- rs1_data, rs2_data  out  DATA_W  register value (combinational).
- rs1_busy, rs2_busy  out  1  operand pending.
- rs1_tag, rs2_tag  out  TAG_W  ROB tag producing the pending operand.
- st_commit  in  5  store source register.
- st_data  out  DATA_W  value of st_commit (combinational, same bypass as rs ports).
- busy_count  out  6  number of busy registers (registered).

Behaviour:
- Reset (rst=0, async): all data, tags and busy bits = 0; busy_count = 0.
  - Every output then reads 0 regardless of selects.
  - Reset asserted mid-operation discards in-flight allocate/commit.
- State per register: data[DATA_W], tag[TAG_W], busy.
- Allocate (posedge, regfile_allocate=1, rd_inflight!=0): busy <= 1, tag <= rob_tag.
  - Re-allocating an already-busy register overwrites the tag; it is renamed to the younger owner.
  - rd_inflight=0 is ignored.
- Commit (posedge, regfile_load=1, commit_rd!=0):
  - data <= (ld_commit_sel ? dmem_rdata : cdb_data), always.
  - busy <= 0 only if busy && tag==commit_tag; otherwise busy and tag are unchanged (a younger writer is pending).
- Same-cycle allocate and commit to the same register: data is written, then allocate wins, so busy=1 and tag=rob_tag.
- Flush (posedge): all busy <= 0; tags are left stale.
  - Same-cycle commit is applied (data written).
  - Same-cycle allocate is applied after the clear, so that register ends busy.
- Read ports, combinational, with commit bypass:
  - If rsX==0: data=0, busy=0, tag=0.
  - Else if regfile_load && commit_rd==rsX && busy && tag==commit_tag: data = commit mux value, busy=0.
  - Else: stored data/busy/tag.
  - Same-cycle allocate is NOT visible on reads; the dispatching instruction sees its pre-rename sources.
  - st_data follows the same rules using st_commit.
- busy_count: registered population count of the next-state busy vector; updated every cycle.
- Latency:
  - Allocate is visible on reads the cycle after.
  - Commit is visible the same cycle via bypass and the cycle after from storage.
- x0 never becomes busy and never stores a non-zero value.

Decomposition:
- Shared package rv32i_types: TAG_W, NUM_REGS, typedef rob_tag_t, and a struct reg_entry_t {data, tag, busy}.
- One sub-module, regfile_read_port (combinational bypass/x0 logic), instantiated three times (rs1, rs2, st).

Test Plan:
- Reset then read x5 -> rs1_data=0, rs1_busy=0, busy_count=0; assert allocate during rst=0 -> no effect.
- Allocate x5 tag 3; next cycle commit x5 tag 3, ld_commit_sel=0, cdb_data=0xDEADBEEF.
  - Required: on the commit cycle rs1=5 gives data 0xDEADBEEF, busy=0 (bypass).
  - Required: afterwards stored value 0xDEADBEEF, busy_count back to 0.
- Allocate x7 tag 1, then x7 tag 4; commit x7 tag 1 with ld_commit_sel=1, dmem_rdata=0x1234.
  - Required: data=0x1234, busy=1, tag=4.
  - Then commit tag 4 -> busy=0.
- Same-cycle allocate x9 tag 2 and commit x9 tag 6 (x9 busy, tag 6), cdb_data=0x55.
  - Required: the read that cycle shows 0x55, busy=0.
  - Required: next cycle shows data 0x55, busy=1, tag=2.
- Busy x1, x2, x3 plus flush with simultaneous allocate x4 tag 5.
  - Required next cycle: x1–x3 not busy, x4 busy with tag 5, busy_count=1.
- Allocate x0 and commit x0 with cdb_data=0xFFFF_FFFF -> rs1=0 reads 0, not busy; st_commit=0 -> st_data=0.

Source files
------------

// File: rtl/regfile_rob_pkg.sv
// Shared types for the ROB-driven architectural register file.
package rv32i_types;

    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned TAG_W    = 3;
    localparam int unsigned REG_AW   = 5;

    typedef logic [TAG_W-1:0]  rob_tag_t;
    typedef logic [REG_AW-1:0] reg_idx_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        rob_tag_t          tag;
        logic              busy;
    } reg_entry_t;

endpackage

// File: rtl/regfile_read_port.sv
// One operand read port: x0 forcing plus same-cycle commit bypass.
module regfile_read_port
    import rv32i_types::*;
(
    input  logic              [REG_AW-1:0] sel,
    input  reg_entry_t                     entry,
    input  logic                           regfile_load,
    input  logic              [REG_AW-1:0] commit_rd,
    input  rob_tag_t                       commit_tag,
    input  logic              [DATA_W-1:0] commit_value,
    output logic              [DATA_W-1:0] data,
    output logic                           busy,
    output rob_tag_t                       tag
);

    always_comb begin
        data = '0;
        busy = 1'b0;
        tag  = '0;
        if (sel != '0) begin
            tag = entry.tag;
            // Only a commit from the current owner resolves the operand early.
            if (regfile_load && commit_rd == sel && entry.busy && entry.tag == commit_tag) begin
                data = commit_value;
                busy = 1'b0;
            end else begin
                data = entry.data;
                busy = entry.busy;
            end
        end
    end

endmodule

// File: rtl/regfile_rob.sv
// Architectural register file with rename tags, driven by ROB allocate/commit.
module regfile_rob
    import rv32i_types::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              regfile_allocate,
    input  logic [REG_AW-1:0] rd_inflight,
    input  rob_tag_t          rob_tag,
    input  logic              regfile_load,
    input  logic [REG_AW-1:0] commit_rd,
    input  rob_tag_t          commit_tag,
    input  logic              ld_commit_sel,
    input  logic [DATA_W-1:0] cdb_data,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              flush,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output rob_tag_t          rs1_tag,
    output rob_tag_t          rs2_tag,
    input  logic [REG_AW-1:0] st_commit,
    output logic [DATA_W-1:0] st_data,
    output logic [5:0]        busy_count
);

    reg_entry_t        regs      [NUM_REGS];
    reg_entry_t        regs_next [NUM_REGS];
    logic [DATA_W-1:0] commit_value;
    logic [5:0]        count_next;
    rob_tag_t          st_tag_unused;
    logic              st_busy_unused;

    assign commit_value = ld_commit_sel ? dmem_rdata : cdb_data;

    // Order matters: flush clears, commit writes, then allocate overrides.
    always_comb begin
        count_next = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_next[i] = regs[i];
            if (i != 0) begin
                if (flush)
                    regs_next[i].busy = 1'b0;
                if (regfile_load && commit_rd == REG_AW'(i)) begin
                    regs_next[i].data = commit_value;
                    if (regs[i].busy && regs[i].tag == commit_tag)
                        regs_next[i].busy = 1'b0;
                end
                if (regfile_allocate && rd_inflight == REG_AW'(i)) begin
                    regs_next[i].busy = 1'b1;
                    regs_next[i].tag  = rob_tag;
                end
            end else begin
                regs_next[i] = '0;
            end
            count_next = count_next + 6'(regs_next[i].busy);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
            busy_count <= '0;
        end else begin
            regs       <= regs_next;
            busy_count <= count_next;
        end
    end

    regfile_read_port u_rs1 (
        .sel(rs1), .entry(regs[rs1]), .regfile_load(regfile_load),
        .commit_rd(commit_rd), .commit_tag(commit_tag), .commit_value(commit_value),
        .data(rs1_data), .busy(rs1_busy), .tag(rs1_tag)
    );

    regfile_read_port u_rs2 (
        .sel(rs2), .entry(regs[rs2]), .regfile_load(regfile_load),
        .commit_rd(commit_rd), .commit_tag(commit_tag), .commit_value(commit_value),
        .data(rs2_data), .busy(rs2_busy), .tag(rs2_tag)
    );

    regfile_read_port u_st (
        .sel(st_commit), .entry(regs[st_commit]), .regfile_load(regfile_load),
        .commit_rd(commit_rd), .commit_tag(commit_tag), .commit_value(commit_value),
        .data(st_data), .busy(st_busy_unused), .tag(st_tag_unused)
    );

endmodule

// File: tb/tb_regfile_rob.sv
// Scoreboard bench for regfile_rob: stimulus queues expectations, a monitor checks them.
module tb_regfile_rob;
    import rv32i_types::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              regfile_allocate;
    logic [4:0]        rd_inflight;
    rob_tag_t          rob_tag;
    logic              regfile_load;
    logic [4:0]        commit_rd;
    rob_tag_t          commit_tag;
    logic              ld_commit_sel;
    logic [31:0]       cdb_data;
    logic [31:0]       dmem_rdata;
    logic              flush;
    logic [4:0]        rs1, rs2, st_commit;
    logic [31:0]       rs1_data, rs2_data, st_data;
    logic              rs1_busy, rs2_busy;
    rob_tag_t          rs1_tag, rs2_tag;
    logic [5:0]        busy_count;

    regfile_rob dut (
        .clk(clk), .rst(rst),
        .regfile_allocate(regfile_allocate), .rd_inflight(rd_inflight), .rob_tag(rob_tag),
        .regfile_load(regfile_load), .commit_rd(commit_rd), .commit_tag(commit_tag),
        .ld_commit_sel(ld_commit_sel), .cdb_data(cdb_data), .dmem_rdata(dmem_rdata),
        .flush(flush), .rs1(rs1), .rs2(rs2),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rs1_tag(rs1_tag), .rs2_tag(rs2_tag),
        .st_commit(st_commit), .st_data(st_data), .busy_count(busy_count)
    );

    always #5 clk = ~clk;

    localparam int K_R1D = 0, K_R1B = 1, K_R1T = 2, K_R2D = 3, K_R2B = 4, K_R2T = 5,
                   K_STD = 6, K_CNT = 7;

    typedef struct {
        string       name;
        int          cyc;
        int          kind;
        logic [31:0] value;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(input int kind);
        case (kind)
            K_R1D:   return rs1_data;
            K_R1B:   return 32'(rs1_busy);
            K_R1T:   return 32'(rs1_tag);
            K_R2D:   return rs2_data;
            K_R2B:   return 32'(rs2_busy);
            K_R2T:   return 32'(rs2_tag);
            K_STD:   return st_data;
            default: return 32'(busy_count);
        endcase
    endfunction

    // Monitor: every expectation is checked on the falling edge of its cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            logic [31:0] a;
            e = q.pop_front();
            a = actual(e.kind);
            checks++;
            if (e.cyc != cyc || a !== e.value) begin
                failures++;
                $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d/%0d)",
                         e.name, a, e.value, cyc, e.cyc);
            end
        end
    end

    task automatic expect_v(input string name, input int kind, input logic [31:0] value);
        exp_t e;
        e.name = name; e.cyc = cyc; e.kind = kind; e.value = value;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        regfile_allocate = 1'b0; rd_inflight = '0; rob_tag = '0;
        regfile_load = 1'b0; commit_rd = '0; commit_tag = '0; ld_commit_sel = 1'b0;
        cdb_data = '0; dmem_rdata = '0; flush = 1'b0;
    endtask

    task automatic alloc(input logic [4:0] r, input rob_tag_t t);
        regfile_allocate = 1'b1; rd_inflight = r; rob_tag = t;
    endtask

    task automatic commit(input logic [4:0] r, input rob_tag_t t, input logic sel,
                          input logic [31:0] cdb, input logic [31:0] dm);
        regfile_load = 1'b1; commit_rd = r; commit_tag = t; ld_commit_sel = sel;
        cdb_data = cdb; dmem_rdata = dm;
    endtask

    initial begin
        rst = 1'b0; rs1 = '0; rs2 = '0; st_commit = '0;
        regfile_allocate = 1'b0; rd_inflight = '0; rob_tag = '0;
        regfile_load = 1'b0; commit_rd = '0; commit_tag = '0; ld_commit_sel = 1'b0;
        cdb_data = '0; dmem_rdata = '0; flush = 1'b0;

        // Reset held while allocating x5: nothing must stick.
        step(); alloc(5, 3); rs1 = 5;
        expect_v("rst_rs1_data", K_R1D, 0);
        expect_v("rst_rs1_busy", K_R1B, 0);
        expect_v("rst_count", K_CNT, 0);
        step(); rst = 1'b1; rs1 = 5;
        expect_v("rst_alloc_ignored", K_R1B, 0);
        expect_v("rst_count2", K_CNT, 0);

        // Allocate x5/3, then commit from CDB.
        step(); alloc(5, 3);
        expect_v("alloc_not_same_cycle", K_R1B, 0);
        step(); commit(5, 3, 1'b0, 32'hDEADBEEF, 32'h0); st_commit = 5;
        expect_v("bypass_x5_data", K_R1D, 32'hDEADBEEF);
        expect_v("bypass_x5_busy", K_R1B, 0);
        expect_v("bypass_x5_st", K_STD, 32'hDEADBEEF);
        expect_v("x5_busy_count", K_CNT, 1);
        step();
        expect_v("x5_stored", K_R1D, 32'hDEADBEEF);
        expect_v("x5_not_busy", K_R1B, 0);
        expect_v("x5_count0", K_CNT, 0);

        // Rename x7 (tag 1 then 4); stale commit writes data but keeps busy.
        step(); alloc(7, 1); rs1 = 7;
        step(); alloc(7, 4);
        expect_v("x7_tag1", K_R1T, 1);
        expect_v("x7_busy", K_R1B, 1);
        step(); commit(7, 1, 1'b1, 32'hAAAA, 32'h1234);
        expect_v("x7_stale_nobypass", K_R1D, 0);
        expect_v("x7_stale_busy", K_R1B, 1);
        expect_v("x7_tag4", K_R1T, 4);
        step();
        expect_v("x7_ld_data", K_R1D, 32'h1234);
        expect_v("x7_still_busy", K_R1B, 1);
        expect_v("x7_tag4_kept", K_R1T, 4);
        expect_v("x7_count1", K_CNT, 1);
        step(); commit(7, 4, 1'b0, 32'h77, 32'h99);
        expect_v("x7_bypass_data", K_R1D, 32'h77);
        expect_v("x7_bypass_busy", K_R1B, 0);
        step();
        expect_v("x7_final_data", K_R1D, 32'h77);
        expect_v("x7_final_busy", K_R1B, 0);
        expect_v("x7_count0", K_CNT, 0);

        // Same-cycle allocate and commit on x9.
        step(); alloc(9, 6); rs1 = 9;
        step(); alloc(9, 2); commit(9, 6, 1'b0, 32'h55, 32'h0);
        expect_v("x9_bypass_data", K_R1D, 32'h55);
        expect_v("x9_bypass_busy", K_R1B, 0);
        step();
        expect_v("x9_data", K_R1D, 32'h55);
        expect_v("x9_busy", K_R1B, 1);
        expect_v("x9_tag", K_R1T, 2);
        expect_v("x9_count", K_CNT, 1);

        // Flush with simultaneous allocate of x4.
        step(); alloc(1, 1);
        step(); alloc(2, 2);
        step(); alloc(3, 3);
        step(); flush = 1'b1; alloc(4, 5);
        expect_v("preflush_count", K_CNT, 4);
        step(); rs1 = 1; rs2 = 3;
        expect_v("flush_x1", K_R1B, 0);
        expect_v("flush_x3", K_R2B, 0);
        expect_v("flush_count", K_CNT, 1);
        step(); rs1 = 4; rs2 = 2;
        expect_v("flush_x4_busy", K_R1B, 1);
        expect_v("flush_x4_tag", K_R1T, 5);
        expect_v("flush_x2", K_R2B, 0);

        // x0 stays zero and never busy.
        step(); alloc(0, 7); commit(0, 7, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rs1 = 0; st_commit = 0;
        expect_v("x0_bypass_data", K_R1D, 0);
        expect_v("x0_st_data", K_STD, 0);
        step(); rs1 = 0; rs2 = 4;
        expect_v("x0_data", K_R1D, 0);
        expect_v("x0_busy", K_R1B, 0);
        expect_v("x0_tag", K_R1T, 0);
        expect_v("x0_count", K_CNT, 1);
        expect_v("x4_tag_rs2", K_R2T, 5);

        // Asynchronous reset mid-operation.
        step(); alloc(10, 1); rst = 1'b0; rs1 = 4;
        expect_v("async_rst_busy", K_R1B, 0);
        expect_v("async_rst_count", K_CNT, 0);
        step(); rst = 1'b1; rs1 = 10; rs2 = 9;
        expect_v("async_rst_x10", K_R1B, 0);
        expect_v("async_rst_x9_data", K_R2D, 0);

        step();
        step();
        if (q.size() != 0) begin
            failures++;
            $display("FAIL leftover: actual=%0d unchecked required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
